// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared beat/source types and constants for the datapath blocks
//
// Purpose: common types used by the datapath source arbiter and its output slice.
//   dp_beat_t : one beat of DP_CH_NUM channels x DP_DWID bits (default geometry)
//   dp_src_e  : source identifier, SRC_A = 0, SRC_B = 1
//   PKT_CNT_W : width of the optional per-source packet counters
package datapath_pkg;

  localparam int DP_DWID   = 24;
  localparam int DP_CH_NUM = 32;
  localparam int PKT_CNT_W = 16;

  typedef logic [DP_CH_NUM-1:0][DP_DWID-1:0] dp_beat_t;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } dp_src_e;

endpackage

// File: rtl/datapath_skid_slice.sv
// rtl/datapath_skid_slice.sv - 2-entry valid/ready/last register slice with a sideband bit
//
// Purpose: fully registered output stage. The main entry drives the output;
// the skid entry catches the one beat that can be accepted while the output
// is stalled, so in_ready is a pure register (!skid occupied).
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready/in_last       upstream beat handshake
//   in_data [W-1:0], in_side        payload and sideband travelling with the beat
//   out_valid/out_ready/out_last    downstream beat handshake (registered)
//   out_data [W-1:0], out_side      registered payload and sideband
module datapath_skid_slice #(
  parameter int W = 768
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_last,
  input  logic [W-1:0] in_data,
  input  logic         in_side,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic [W-1:0] out_data,
  output logic         out_side
);

  logic         m_valid_q, m_valid_d;
  logic         m_last_q,  m_last_d;
  logic         m_side_q,  m_side_d;
  logic [W-1:0] m_data_q,  m_data_d;
  logic         s_valid_q, s_valid_d;
  logic         s_last_q,  s_last_d;
  logic         s_side_q,  s_side_d;
  logic [W-1:0] s_data_q,  s_data_d;

  logic out_fire;
  logic in_fire;

  assign in_ready  = !s_valid_q;
  assign out_valid = m_valid_q;
  assign out_last  = m_last_q;
  assign out_data  = m_data_q;
  assign out_side  = m_side_q;

  always_comb begin
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_side_d  = m_side_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_last_d  = s_last_q;
    s_side_d  = s_side_q;
    s_data_d  = s_data_q;
    out_fire  = m_valid_q && out_ready;
    in_fire   = in_valid && !s_valid_q;

    if (s_valid_q) begin
      // Input is blocked while the skid is occupied; only a drain can happen.
      if (out_fire) begin
        m_valid_d = 1'b1;
        m_last_d  = s_last_q;
        m_side_d  = s_side_q;
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end
    end else if (!m_valid_q || out_fire) begin
      // Main is free (or leaving this cycle): a new beat goes straight to main.
      m_valid_d = in_fire;
      if (in_fire) begin
        m_last_d = in_last;
        m_side_d = in_side;
        m_data_d = in_data;
      end
    end else if (in_fire) begin
      // Main is stalled: park the beat in skid, which drops in_ready next cycle.
      s_valid_d = 1'b1;
      s_last_d  = in_last;
      s_side_d  = in_side;
      s_data_d  = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_side_q  <= 1'b0;
      m_data_q  <= '0;
      s_valid_q <= 1'b0;
      s_last_q  <= 1'b0;
      s_side_q  <= 1'b0;
      s_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_side_q  <= m_side_d;
      m_data_q  <= m_data_d;
      s_valid_q <= s_valid_d;
      s_last_q  <= s_last_d;
      s_side_q  <= s_side_d;
      s_data_q  <= s_data_d;
    end
  end

endmodule

// File: rtl/datapath_src_arb2.sv
// rtl/datapath_src_arb2.sv - packet-granular 2:1 round-robin source arbiter with registered output
//
// Purpose: merges beat streams A and B into Z. A packet owns Z from its first
// accepted beat until its last beat is accepted; between packets the preferred
// source rotates away from the previous winner.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   A_valid/A_ready/A_last/A_data      source A beat stream
//   B_valid/B_ready/B_last/B_data      source B beat stream
//   Z_valid/Z_ready/Z_last/Z_data      registered output beat stream
//   Z_src                              source of the beat on Z (0 = A, 1 = B)
//   busy                               packet lock held or output slice non-empty
//   A_pkt_cnt, B_pkt_cnt               completed-packet counters, present only
//                                      when DATAPATH_ARB2_PKT_CNT_EN is defined
module datapath_src_arb2
  import datapath_pkg::*;
#(
  parameter int DWID   = 24,
  parameter int CH_NUM = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         A_valid,
  output logic                         A_ready,
  input  logic                         A_last,
  input  logic [CH_NUM-1:0][DWID-1:0]  A_data,
  input  logic                         B_valid,
  output logic                         B_ready,
  input  logic                         B_last,
  input  logic [CH_NUM-1:0][DWID-1:0]  B_data,
  output logic                         Z_valid,
  input  logic                         Z_ready,
  output logic                         Z_last,
  output logic [CH_NUM-1:0][DWID-1:0]  Z_data,
  output logic                         Z_src,
  output logic                         busy
`ifdef DATAPATH_ARB2_PKT_CNT_EN
  ,
  output logic [PKT_CNT_W-1:0]         A_pkt_cnt,
  output logic [PKT_CNT_W-1:0]         B_pkt_cnt
`endif
);

  localparam int W = CH_NUM * DWID;

  logic    locked_q, locked_d;
  dp_src_e sel_q,    sel_d;
  dp_src_e prio_q,   prio_d;

  dp_src_e                     pick;
  logic                        pick_valid;
  logic                        slice_in_ready;
  logic                        slice_full;
  logic                        in_valid;
  logic                        in_last;
  logic [CH_NUM-1:0][DWID-1:0] in_data;
  logic                        fire;

  // Effective pick: the locked source, else prio if valid, else the other if valid.
  always_comb begin
    pick       = prio_q;
    pick_valid = 1'b0;
    if (locked_q) begin
      pick       = sel_q;
      pick_valid = 1'b1;
    end else if ((prio_q == SRC_A) ? A_valid : B_valid) begin
      pick       = prio_q;
      pick_valid = 1'b1;
    end else if ((prio_q == SRC_A) ? B_valid : A_valid) begin
      pick       = (prio_q == SRC_A) ? SRC_B : SRC_A;
      pick_valid = 1'b1;
    end
  end

  assign slice_full = !slice_in_ready;

  // While locked, ready stays with the owner even across its valid gaps.
  assign A_ready = pick_valid && (pick == SRC_A) && !slice_full;
  assign B_ready = pick_valid && (pick == SRC_B) && !slice_full;

  assign in_valid = pick_valid && ((pick == SRC_B) ? B_valid : A_valid);
  assign in_last  = (pick == SRC_B) ? B_last : A_last;
  assign in_data  = (pick == SRC_B) ? B_data : A_data;
  assign fire     = in_valid && !slice_full;

  always_comb begin
    locked_d = locked_q;
    sel_d    = sel_q;
    prio_d   = prio_q;
    if (fire) begin
      if (in_last) begin
        locked_d = 1'b0;
        prio_d   = (pick == SRC_A) ? SRC_B : SRC_A;
      end else begin
        locked_d = 1'b1;
        sel_d    = pick;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q <= 1'b0;
      sel_q    <= SRC_A;
      prio_q   <= SRC_A;
    end else begin
      locked_q <= locked_d;
      sel_q    <= sel_d;
      prio_q   <= prio_d;
    end
  end

  datapath_skid_slice #(
    .W (W)
  ) u_z_slice (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (slice_in_ready),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_side   (pick),
    .out_valid (Z_valid),
    .out_ready (Z_ready),
    .out_last  (Z_last),
    .out_data  (Z_data),
    .out_side  (Z_src)
  );

  assign busy = locked_q || Z_valid || slice_full;

`ifdef DATAPATH_ARB2_PKT_CNT_EN
  logic [PKT_CNT_W-1:0] a_cnt_q, a_cnt_d;
  logic [PKT_CNT_W-1:0] b_cnt_q, b_cnt_d;

  always_comb begin
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    if (fire && in_last) begin
      if (pick == SRC_A) a_cnt_d = a_cnt_q + 1'b1;
      else               b_cnt_d = b_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
    end
  end

  assign A_pkt_cnt = a_cnt_q;
  assign B_pkt_cnt = b_cnt_q;
`endif

endmodule

// File: tb/tb_datapath_src_arb2.sv
// tb/tb_datapath_src_arb2.sv - self-checking bench for datapath_src_arb2
module tb_datapath_src_arb2;

  typedef logic [31:0][23:0] beat_t;

  logic        clk;
  logic        rst_n;
  logic        A_valid, A_ready, A_last;
  beat_t       A_data;
  logic        B_valid, B_ready, B_last;
  beat_t       B_data;
  logic        Z_valid, Z_ready, Z_last, Z_src, busy;
  beat_t       Z_data;
`ifdef DATAPATH_ARB2_PKT_CNT_EN
  logic [15:0] A_pkt_cnt, B_pkt_cnt;
`endif

  datapath_src_arb2 #(.DWID(24), .CH_NUM(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A_valid (A_valid),
    .A_ready (A_ready),
    .A_last  (A_last),
    .A_data  (A_data),
    .B_valid (B_valid),
    .B_ready (B_ready),
    .B_last  (B_last),
    .B_data  (B_data),
    .Z_valid (Z_valid),
    .Z_ready (Z_ready),
    .Z_last  (Z_last),
    .Z_data  (Z_data),
    .Z_src   (Z_src),
    .busy    (busy)
`ifdef DATAPATH_ARB2_PKT_CNT_EN
    ,
    .A_pkt_cnt (A_pkt_cnt),
    .B_pkt_cnt (B_pkt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic chkd(input string nm, input beat_t act, input beat_t exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic beat_t mk(input logic [23:0] v);
    beat_t b;
    for (int i = 0; i < 32; i++) b[i] = v + 24'(i);
    return b;
  endfunction

  // Reference model: output slice as a FIFO of depth 2, arbitration from the rules.
  typedef struct {
    beat_t d;
    logic  last;
    logic  src;
  } mbeat_t;

  mbeat_t  mq[$];
  bit      m_locked;
  int      m_sel, m_prio;
  int      m_cnt[2];
  bit      nx_acc, nx_pop;
  int      nx_pk;
  mbeat_t  nx_beat;
  bit      acc_a, acc_b;

  task automatic model_reset();
    mq.delete();
    m_locked = 0;
    m_sel    = 0;
    m_prio   = 0;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
  endtask

  task automatic model_check();
    bit v[2];
    bit er[2];
    bit pv;
    int pk;
    v[0] = A_valid;
    v[1] = B_valid;
    pv = 0;
    pk = 0;
    if (m_locked) begin
      pk = m_sel;
      pv = 1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        int s = (m_prio + k) % 2;
        if (!pv && v[s]) begin
          pk = s;
          pv = 1;
        end
      end
    end
    er[0] = pv && pk == 0 && mq.size() < 2;
    er[1] = pv && pk == 1 && mq.size() < 2;
    chk1("m_a_ready", A_ready, er[0]);
    chk1("m_b_ready", B_ready, er[1]);
    chk1("m_z_valid", Z_valid, mq.size() > 0);
    chk1("m_busy", busy, m_locked || mq.size() > 0);
    if (mq.size() > 0) begin
      chkd("m_z_data", Z_data, mq[0].d);
      chk1("m_z_last", Z_last, mq[0].last);
      chk1("m_z_src", Z_src, mq[0].src);
    end
    nx_pk        = pk;
    nx_acc       = pv && v[pk] && er[pk];
    nx_pop       = mq.size() > 0 && Z_ready;
    nx_beat.d    = (pk == 1) ? B_data : A_data;
    nx_beat.last = (pk == 1) ? B_last : A_last;
    nx_beat.src  = (pk == 1);
  endtask

  task automatic model_update();
    if (nx_pop) void'(mq.pop_front());
    if (nx_acc) begin
      mq.push_back(nx_beat);
      if (nx_beat.last) begin
        m_locked = 0;
        m_prio   = 1 - nx_pk;
        m_cnt[nx_pk]++;
      end else begin
        m_locked = 1;
        m_sel    = nx_pk;
      end
    end
  endtask

  task automatic step();
    #1;
    model_check();
    acc_a = A_valid && A_ready;
    acc_b = B_valid && B_ready;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    A_valid = 0; A_last = 0; A_data = '0;
    B_valid = 0; B_last = 0; B_data = '0;
  endtask

  // ctl = {A_valid, A_last, B_valid, B_last, Z_ready}
  // ex  = {A_ready, B_ready, Z_valid, Z_last, Z_src, busy}
  typedef struct {
    logic [4:0]  ctl;
    logic [23:0] ad;
    logic [23:0] bd;
    logic [5:0]  ex;
    logic [23:0] zd;
  } vec_t;

  vec_t tbl[19];

  logic [31:0] r;
  bit          pend_a, pend_b, lst_a, lst_b;
  logic [23:0] val_a, val_b;

  initial begin
    rst_n   = 1'b1;
    Z_ready = 1'b0;
    idle_inputs();
    model_reset();

    // reset values
    #1 rst_n = 1'b0;
    #1;
    chk1("rst_z_valid", Z_valid, 1'b0);
    chk1("rst_z_last", Z_last, 1'b0);
    chkd("rst_z_data", Z_data, '0);
    chk1("rst_z_src", Z_src, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_a_ready", A_ready, 1'b0);
    chk1("rst_b_ready", B_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    Z_ready = 1'b1;

    // 3-beat A packet, B single beat, A/B alternation, single-beat rotation
    tbl[0]  = '{5'b00_00_1, 24'h00, 24'h00, 6'b000000, 24'h00};
    tbl[1]  = '{5'b10_00_1, 24'h01, 24'h00, 6'b100000, 24'h00};
    tbl[2]  = '{5'b10_00_1, 24'h02, 24'h00, 6'b101001, 24'h01};
    tbl[3]  = '{5'b11_00_1, 24'h03, 24'h00, 6'b101001, 24'h02};
    tbl[4]  = '{5'b00_00_1, 24'h00, 24'h00, 6'b001101, 24'h03};
    tbl[5]  = '{5'b00_11_1, 24'h00, 24'h50, 6'b010000, 24'h00};
    tbl[6]  = '{5'b10_10_1, 24'h11, 24'h21, 6'b101111, 24'h50};
    tbl[7]  = '{5'b11_10_1, 24'h12, 24'h21, 6'b101001, 24'h11};
    tbl[8]  = '{5'b10_10_1, 24'h13, 24'h21, 6'b011101, 24'h12};
    tbl[9]  = '{5'b10_11_1, 24'h13, 24'h22, 6'b011011, 24'h21};
    tbl[10] = '{5'b10_10_1, 24'h13, 24'h23, 6'b101111, 24'h22};
    tbl[11] = '{5'b11_10_1, 24'h14, 24'h23, 6'b101001, 24'h13};
    tbl[12] = '{5'b00_00_1, 24'h00, 24'h00, 6'b001101, 24'h14};
    tbl[13] = '{5'b00_11_1, 24'h00, 24'h30, 6'b010000, 24'h00};
    tbl[14] = '{5'b11_10_1, 24'h31, 24'h32, 6'b101111, 24'h30};
    tbl[15] = '{5'b10_10_1, 24'h33, 24'h32, 6'b011101, 24'h31};
    tbl[16] = '{5'b10_11_1, 24'h33, 24'h34, 6'b011011, 24'h32};
    tbl[17] = '{5'b00_00_1, 24'h00, 24'h00, 6'b001111, 24'h34};
    tbl[18] = '{5'b00_00_1, 24'h00, 24'h00, 6'b000000, 24'h00};

    for (int i = 0; i < 19; i++) begin
      A_valid = tbl[i].ctl[4];
      A_last  = tbl[i].ctl[3];
      B_valid = tbl[i].ctl[2];
      B_last  = tbl[i].ctl[1];
      Z_ready = tbl[i].ctl[0];
      A_data  = mk(tbl[i].ad);
      B_data  = mk(tbl[i].bd);
      #1;
      chk1($sformatf("tbl%0d_a_ready", i), A_ready, tbl[i].ex[5]);
      chk1($sformatf("tbl%0d_b_ready", i), B_ready, tbl[i].ex[4]);
      chk1($sformatf("tbl%0d_z_valid", i), Z_valid, tbl[i].ex[3]);
      chk1($sformatf("tbl%0d_busy", i), busy, tbl[i].ex[0]);
      if (tbl[i].ex[3]) begin
        chk1($sformatf("tbl%0d_z_last", i), Z_last, tbl[i].ex[2]);
        chk1($sformatf("tbl%0d_z_src", i), Z_src, tbl[i].ex[1]);
        chkd($sformatf("tbl%0d_z_data", i), Z_data, mk(tbl[i].zd));
      end
      step();
    end

    // B locks on beat 1 of 4, then gaps while A waits
    idle_inputs();
    B_valid = 1; B_data = mk(24'h301);
    step();
    B_valid = 0;
    A_valid = 1; A_last = 1; A_data = mk(24'h3A1);
    for (int i = 0; i < 3; i++) begin
      #1 chk1("gap_a_blocked", A_ready, 1'b0);
      step();
    end
    for (int i = 2; i <= 4; i++) begin
      B_valid = 1; B_data = mk(24'h300 + 24'(i)); B_last = (i == 4);
      #1 chk1("lock_a_blocked", A_ready, 1'b0);
      step();
    end
    B_valid = 0; B_last = 0;
    #1 chk1("a_wins_after_b", A_ready, 1'b1);
    step();
    idle_inputs();
    repeat (2) step();

    // Z stalled for 5 cycles during a 5-beat A packet
    A_valid = 1; A_data = mk(24'h401);
    step();
    Z_ready = 0;
    A_data = mk(24'h402);
    #1 chk1("stall_first_accept", A_ready, 1'b1);
    step();
    A_data = mk(24'h403);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1("stall_a_ready", A_ready, 1'b0);
      chkd("stall_z_hold", Z_data, mk(24'h401));
      chk1("stall_z_valid", Z_valid, 1'b1);
      step();
    end
    Z_ready = 1;
    begin
      int k = 3;
      for (int c = 0; c < 12 && k <= 5; c++) begin
        A_valid = 1; A_data = mk(24'h400 + 24'(k)); A_last = (k == 5);
        step();
        if (acc_a) k++;
      end
      chk1("stall_all_sent", k > 5, 1'b1);
    end
    idle_inputs();
    repeat (3) step();

    // reset mid-packet with two beats buffered
    Z_ready = 0;
    A_valid = 1; A_data = mk(24'h601);
    step();
    A_data = mk(24'h602);
    step();
    chk1("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_z_valid", Z_valid, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    A_valid = 0;
    #1;
    chk1("mid_rst_a_ready", A_ready, 1'b0);
    chk1("mid_rst_b_ready", B_ready, 1'b0);
`ifdef DATAPATH_ARB2_PKT_CNT_EN
    chk16("rst_a_pkt_cnt", A_pkt_cnt, 16'd0);
    chk16("rst_b_pkt_cnt", B_pkt_cnt, 16'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    Z_ready = 1;
    idle_inputs();
    B_valid = 1; B_last = 1; B_data = mk(24'h6B1);
    #1;
    chk1("post_rst_b_granted", B_ready, 1'b1);
    chk1("post_rst_a_idle", A_ready, 1'b0);
    step();
    idle_inputs();
    step();
    chk1("post_rst_z_src", Z_src, 1'b1);

    // randomized traffic against the reference model
    pend_a = 0; pend_b = 0; acc_a = 0; acc_b = 0;
    val_a = '0; val_b = '0; lst_a = 0; lst_b = 0;
    for (int c = 0; c < 3000; c++) begin
      if (acc_a) pend_a = 0;
      if (acc_b) pend_b = 0;
      if (!pend_a && $urandom_range(0, 99) < 55) begin
        r = $urandom(); val_a = r[23:0]; pend_a = 1;
        lst_a = ($urandom_range(0, 2) == 0);
      end
      if (!pend_b && $urandom_range(0, 99) < 55) begin
        r = $urandom(); val_b = r[23:0]; pend_b = 1;
        lst_b = ($urandom_range(0, 2) == 0);
      end
      A_valid = pend_a; A_last = lst_a; A_data = mk(val_a);
      B_valid = pend_b; B_last = lst_b; B_data = mk(val_b);
      Z_ready = ($urandom_range(0, 99) < 70);
      step();
    end
`ifdef DATAPATH_ARB2_PKT_CNT_EN
    chk16("a_pkt_cnt", A_pkt_cnt, 16'(m_cnt[0]));
    chk16("b_pkt_cnt", B_pkt_cnt, 16'(m_cnt[1]));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
